// File: rtl/regfile_pkg.sv
// Shared pipeline definitions: register file geometry, data bus type and writeback port bundle.
package pipeline_defines;

   localparam int RegNumLog2 = 5;
   localparam int RegNum     = 32;

   typedef logic [31:0] RegBus;

   typedef struct packed {
      logic                  valid;
      logic [RegNumLog2-1:0] addr;
      RegBus                 data;
   } wb_regfile_struct;

   // Selects reg1 (sel=0) or reg2 (sel=1) out of a packed {reg2, reg1} address pair.
   function automatic logic [RegNumLog2-1:0] rd_field(input logic [2*RegNumLog2-1:0] pair,
                                                      input logic sel);
      return sel ? pair[2*RegNumLog2-1:RegNumLog2] : pair[RegNumLog2-1:0];
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Dispatch/writeback bundle between the pipeline (master) and the register file (slave).
interface regfile_if #(parameter int DECODE_WIDTH = 2);
   import pipeline_defines::*;

   logic [DECODE_WIDTH-1:0][1:0]              read_valid_i;
   logic [DECODE_WIDTH-1:0][RegNumLog2*2-1:0] read_addr_i;
   logic [DECODE_WIDTH-1:0][1:0][31:0]        read_data_o;
   logic [DECODE_WIDTH-1:0][1:0]              read_busy_o;
   logic [DECODE_WIDTH-1:0]                   wb_valid_i;
   logic [DECODE_WIDTH-1:0][RegNumLog2-1:0]   wb_addr_i;
   logic [DECODE_WIDTH-1:0][31:0]             wb_data_i;
   logic [DECODE_WIDTH-1:0]                   issue_valid_i;
   logic [DECODE_WIDTH-1:0][RegNumLog2-1:0]   issue_addr_i;
   logic                                      flush_i;

   modport master (
      output read_valid_i, read_addr_i, wb_valid_i, wb_addr_i, wb_data_i,
             issue_valid_i, issue_addr_i, flush_i,
      input  read_data_o, read_busy_o
   );

   modport slave (
      input  read_valid_i, read_addr_i, wb_valid_i, wb_addr_i, wb_data_i,
             issue_valid_i, issue_addr_i, flush_i,
      output read_data_o, read_busy_o
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per architectural register marking an in-flight producer.
module regfile_scoreboard
   import pipeline_defines::*;
#(
   parameter int DECODE_WIDTH = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [DECODE_WIDTH-1:0]                 issue_valid,
   input  logic [DECODE_WIDTH-1:0][RegNumLog2-1:0] issue_addr,
   input  logic [DECODE_WIDTH-1:0]                 wb_valid,
   input  logic [DECODE_WIDTH-1:0][RegNumLog2-1:0] wb_addr,
   input  logic                                    flush,
   input  logic [DECODE_WIDTH-1:0][1:0][RegNumLog2-1:0] rd_addr,
   output logic [DECODE_WIDTH-1:0][1:0]            rd_busy
);

   logic [RegNum-1:0] busy;
   logic [RegNum-1:0] busy_nxt;

   // Clears first, then sets: a same-cycle issue is the newer producer; flush trumps both.
   always_comb begin
      busy_nxt = busy;
      for (int l = 0; l < DECODE_WIDTH; l++) begin
         if (wb_valid[l]) busy_nxt[wb_addr[l]] = 1'b0;
      end
      for (int l = 0; l < DECODE_WIDTH; l++) begin
         if (issue_valid[l]) busy_nxt[issue_addr[l]] = 1'b1;
      end
      if (flush) busy_nxt = '0;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   always_comb begin
      rd_busy = '0;
      for (int l = 0; l < DECODE_WIDTH; l++) begin
         for (int p = 0; p < 2; p++) rd_busy[l][p] = busy[rd_addr[l][p]];
      end
   end

endmodule

// File: rtl/regfile.sv
// Architectural register file with busy scoreboard; same-cycle writeback bypass when
// REGFILE_BYPASS_EN is defined.
module regfile
   import pipeline_defines::*;
#(
   parameter int DECODE_WIDTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   regfile_if.slave  bus
);

   wb_regfile_struct                            wb [DECODE_WIDTH];
   RegBus                                       mem [RegNum];
   logic [DECODE_WIDTH-1:0][1:0][RegNumLog2-1:0] rd_addr;
   logic [DECODE_WIDTH-1:0][1:0]                 stored_busy;

   always_comb begin
      for (int l = 0; l < DECODE_WIDTH; l++) begin
         wb[l] = '{valid: bus.wb_valid_i[l], addr: bus.wb_addr_i[l], data: bus.wb_data_i[l]};
         for (int p = 0; p < 2; p++) rd_addr[l][p] = rd_field(bus.read_addr_i[l], p[0]);
      end
   end

   // Lanes are applied in ascending order so the highest lane wins an address conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < RegNum; r++) mem[r] <= '0;
      end else begin
         for (int l = 0; l < DECODE_WIDTH; l++) begin
            if (wb[l].valid && wb[l].addr != '0) mem[wb[l].addr] <= wb[l].data;
         end
      end
   end

   regfile_scoreboard #(.DECODE_WIDTH(DECODE_WIDTH)) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (bus.issue_valid_i),
      .issue_addr  (bus.issue_addr_i),
      .wb_valid    (bus.wb_valid_i),
      .wb_addr     (bus.wb_addr_i),
      .flush       (bus.flush_i),
      .rd_addr     (rd_addr),
      .rd_busy     (stored_busy)
   );

   always_comb begin
      bus.read_data_o = '0;
      bus.read_busy_o = '0;
      for (int l = 0; l < DECODE_WIDTH; l++) begin
         for (int p = 0; p < 2; p++) begin
            if (rst_n && bus.read_valid_i[l][p] && rd_addr[l][p] != '0) begin
               bus.read_data_o[l][p] = mem[rd_addr[l][p]];
               bus.read_busy_o[l][p] = stored_busy[l][p];
`ifdef REGFILE_BYPASS_EN
               // A same-cycle issue keeps the stored busy; its own set shows up next cycle.
               for (int w = 0; w < DECODE_WIDTH; w++) begin
                  if (wb[w].valid && wb[w].addr == rd_addr[l][p]) begin
                     bus.read_data_o[l][p] = wb[w].data;
                     bus.read_busy_o[l][p] = 1'b0;
                  end
               end
               for (int w = 0; w < DECODE_WIDTH; w++) begin
                  if (bus.issue_valid_i[w] && bus.issue_addr_i[w] == rd_addr[l][p])
                     bus.read_busy_o[l][p] = stored_busy[l][p];
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed test-plan cases plus randomized traffic,
// all compared against a register/busy array model every cycle.
module tb_regfile;

   localparam int DW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   regfile_if #(.DECODE_WIDTH(DW)) bus ();

   regfile #(.DECODE_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] m_reg  [32];
   logic        m_busy [32];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] raddr(input int l, input int p);
      logic [9:0] pair;
      pair = bus.read_addr_i[l];
      return (p == 0) ? pair[4:0] : pair[9:5];
   endfunction

   function automatic logic [31:0] exp_data(input int l, input int p);
      logic [4:0]  a;
      logic [31:0] d;
      a = raddr(l, p);
      if (!rst_n || !bus.read_valid_i[l][p] || a == 5'd0) return 32'h0;
      d = m_reg[a];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < DW; w++)
         if (bus.wb_valid_i[w] && bus.wb_addr_i[w] == a) d = bus.wb_data_i[w];
`endif
      return d;
   endfunction

   function automatic logic exp_busy(input int l, input int p);
      logic [4:0] a;
      logic hit, iss;
      a = raddr(l, p);
      if (!rst_n || !bus.read_valid_i[l][p] || a == 5'd0) return 1'b0;
      hit = 1'b0;
      iss = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < DW; w++) begin
         if (bus.wb_valid_i[w] && bus.wb_addr_i[w] == a) hit = 1'b1;
         if (bus.issue_valid_i[w] && bus.issue_addr_i[w] == a) iss = 1'b1;
      end
`endif
      return (hit && !iss) ? 1'b0 : m_busy[a];
   endfunction

   function automatic void model_clear();
      for (int r = 0; r < 32; r++) begin
         m_reg[r]  = 32'h0;
         m_busy[r] = 1'b0;
      end
   endfunction

   // Architectural effect of one clock edge, from the rules of the register file.
   function automatic void model_edge();
      logic set, clr;
      if (!rst_n) return;
      for (int r = 1; r < 32; r++) begin
         set = 1'b0;
         clr = 1'b0;
         for (int l = 0; l < DW; l++) begin
            if (bus.issue_valid_i[l] && bus.issue_addr_i[l] == 5'(r)) set = 1'b1;
            if (bus.wb_valid_i[l] && bus.wb_addr_i[l] == 5'(r)) clr = 1'b1;
         end
         if (bus.flush_i)  m_busy[r] = 1'b0;
         else if (set)     m_busy[r] = 1'b1;
         else if (clr)     m_busy[r] = 1'b0;
      end
      for (int l = 0; l < DW; l++)
         if (bus.wb_valid_i[l] && bus.wb_addr_i[l] != 5'd0) m_reg[bus.wb_addr_i[l]] = bus.wb_data_i[l];
   endfunction

   always @(negedge clk) begin
      for (int l = 0; l < DW; l++) begin
         for (int p = 0; p < 2; p++) begin
            check($sformatf("rd_data[%0d][%0d]", l, p), bus.read_data_o[l][p], exp_data(l, p));
            check($sformatf("rd_busy[%0d][%0d]", l, p), {31'b0, bus.read_busy_o[l][p]},
                  {31'b0, exp_busy(l, p)});
         end
      end
   end

   task automatic idle();
      bus.read_valid_i  = '0;
      bus.read_addr_i   = '0;
      bus.wb_valid_i    = '0;
      bus.wb_addr_i     = '0;
      bus.wb_data_i     = '0;
      bus.issue_valid_i = '0;
      bus.issue_addr_i  = '0;
      bus.flush_i       = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rd(input int l, input int p, input logic [4:0] a);
      bus.read_valid_i[l][p] = 1'b1;
      if (p == 0) bus.read_addr_i[l][4:0] = a;
      else        bus.read_addr_i[l][9:5] = a;
   endtask

   task automatic wb(input int l, input logic [4:0] a, input logic [31:0] d);
      bus.wb_valid_i[l] = 1'b1;
      bus.wb_addr_i[l]  = a;
      bus.wb_data_i[l]  = d;
   endtask

   task automatic iss(input int l, input logic [4:0] a);
      bus.issue_valid_i[l] = 1'b1;
      bus.issue_addr_i[l]  = a;
   endtask

   initial begin
      model_clear();
      idle();
      for (int l = 0; l < DW; l++) for (int p = 0; p < 2; p++) rd(l, p, 5'd17);
      iss(0, 5'd17);
      wb(1, 5'd17, 32'hDEADBEEF);
      #1;
      check("in_reset_data", bus.read_data_o[0][0], 32'h0);
      step();
      step();
      rst_n = 1'b1;
      idle();

      // After reset every register reads zero and idle.
      for (int r = 1; r < 32; r++) begin
         for (int l = 0; l < DW; l++) for (int p = 0; p < 2; p++) rd(l, p, 5'(r));
         step();
      end
      #1;
      check("reset_r31", bus.read_data_o[1][1], 32'h0);

      // r0 is hardwired.
      idle();
      wb(0, 5'd0, 32'hFFFFFFFF);
      step();
      idle();
      rd(0, 0, 5'd0);
      rd(1, 1, 5'd0);
      #1;
      check("r0_zero", bus.read_data_o[0][0], 32'h0);

      // Write r5, same-cycle and next-cycle reads.
      idle();
      wb(0, 5'd5, 32'h12345678);
      rd(0, 0, 5'd5);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("r5_same_cycle", bus.read_data_o[0][0], 32'h12345678);
`else
      check("r5_same_cycle", bus.read_data_o[0][0], 32'h0);
`endif
      step();
      idle();
      rd(1, 1, 5'd5);
      #1;
      check("r5_next_cycle", bus.read_data_o[1][1], 32'h12345678);

      // Write conflict: highest lane wins.
      idle();
      wb(0, 5'd7, 32'hAAAA0000);
      wb(1, 5'd7, 32'h5555FFFF);
      step();
      idle();
      rd(0, 1, 5'd7);
      #1;
      check("r7_conflict", bus.read_data_o[0][1], 32'h5555FFFF);

      // Scoreboard set / clear / set-wins.
      idle();
      iss(1, 5'd9);
      step();
      idle();
      rd(0, 0, 5'd9);
      #1;
      check("r9_busy_set", {31'b0, bus.read_busy_o[0][0]}, 32'd1);
      wb(0, 5'd9, 32'h00000099);
      #1;
`ifdef REGFILE_BYPASS_EN
      check("r9_wb_same", {31'b0, bus.read_busy_o[0][0]}, 32'd0);
`else
      check("r9_wb_same", {31'b0, bus.read_busy_o[0][0]}, 32'd1);
`endif
      step();
      idle();
      rd(0, 0, 5'd9);
      #1;
      check("r9_busy_clr", {31'b0, bus.read_busy_o[0][0]}, 32'd0);
      iss(0, 5'd9);
      wb(1, 5'd9, 32'h00000999);
      step();
      idle();
      rd(0, 0, 5'd9);
      #1;
      check("r9_set_wins", {31'b0, bus.read_busy_o[0][0]}, 32'd1);

      // Flush overrides a same-cycle issue.
      idle();
      iss(0, 5'd3);
      iss(1, 5'd4);
      step();
      idle();
      bus.flush_i = 1'b1;
      iss(0, 5'd6);
      step();
      idle();
      rd(0, 0, 5'd3);
      rd(0, 1, 5'd4);
      rd(1, 0, 5'd6);
      rd(1, 1, 5'd9);
      #1;
      check("flush_busy", {28'b0, bus.read_busy_o[1], bus.read_busy_o[0]}, 32'h0);

      // Async reset mid-stream clears data and busy.
      idle();
      wb(0, 5'd2, 32'hCAFEF00D);
      iss(1, 5'd2);
      step();
      idle();
      rd(0, 0, 5'd2);
      #1;
      check("r2_written", bus.read_data_o[0][0], 32'hCAFEF00D);
      rst_n = 1'b0;
      model_clear();
      #1;
      check("r2_in_reset", bus.read_data_o[0][0], 32'h0);
      step();
      rst_n = 1'b1;
      idle();
      rd(0, 0, 5'd2);
      wb(1, 5'd10, 32'h0BADC0DE);
      #1;
      check("r2_after_rst", {bus.read_data_o[0][0][30:0], bus.read_busy_o[0][0]}, 32'h0);
      step();
      idle();
      rd(1, 0, 5'd10);
      #1;
      check("first_edge_wr", bus.read_data_o[1][0], 32'h0BADC0DE);

      // Randomized traffic, half the time on a narrow address window to force collisions.
      for (int c = 0; c < 600; c++) begin
         logic [4:0] mask;
         mask = ($urandom_range(0, 1) == 0) ? 5'h07 : 5'h1F;
         idle();
         bus.read_valid_i = 4'($urandom);
         bus.read_addr_i  = 20'($urandom) & {mask, mask, mask, mask};
         for (int l = 0; l < DW; l++) begin
            if ($urandom_range(0, 2) == 0) wb(l, 5'($urandom) & mask, $urandom);
            if ($urandom_range(0, 2) == 0) iss(l, 5'($urandom) & mask);
         end
         bus.flush_i = ($urandom_range(0, 15) == 0);
         step();
      end

      idle();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile.md
# regfile

Architectural integer register file plus busy scoreboard: the responder to the dispatch stage's per-lane register read requests, and the sink for writeback. It serves 2 read ports per lane combinationally, so dispatch registers operands on the next edge. It commits up to DECODE_WIDTH writebacks per cycle and tracks which registers have an in-flight producer.

## Interface
- DECODE_WIDTH, 2: number of lanes (read pairs, write ports, issue ports).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- read_valid_i  in  [DECODE_WIDTH][2]  per-lane read enable, index 0 = reg1, 1 = reg2.
- read_addr_i  in  [DECODE_WIDTH][RegNumLog2*2]  packed {reg2, reg1} addresses.
- read_data_o  out  [DECODE_WIDTH][2][32]  read result, [i][0] = reg1, [i][1] = reg2.
- read_busy_o  out  [DECODE_WIDTH][2]  operand has a pending producer.
- wb_valid_i  in  [DECODE_WIDTH]  writeback valid.
- wb_addr_i  in  [DECODE_WIDTH][RegNumLog2]  writeback destination.
- wb_data_i  in  [DECODE_WIDTH][32]  writeback data.
- issue_valid_i  in  [DECODE_WIDTH]  dispatch issued an instruction that writes a register.
- issue_addr_i  in  [DECODE_WIDTH][RegNumLog2]  its destination.
- flush_i  in  1  pipeline flush; clears scoreboard.

## Operation
- Storage: 32 x 32-bit. r0 reads 0 always; writes and issues to r0 are ignored.
- Read: combinational. read_valid low -> data 0, busy 0. Address 0 -> data 0, busy 0.
- Write: at posedge, for each lane with wb_valid and addr != 0, reg[addr] <= data.
- Write conflict, both lanes same addr: the highest lane index wins.
- Scoreboard, per register:
  - busy set at posedge by issue_valid with addr != 0.
  - Cleared at posedge by wb_valid to the same addr.
  - Set and clear of the same reg in one cycle: set wins, because the issue is the newer producer.
  - flush_i clears all busy bits and overrides same-cycle sets. Register data writes still commit during flush.
- read_busy_o = busy[addr], with the bypass qualification below.
- Reset: all registers 0, all busy 0. read_data_o and read_busy_o are 0 for every input while in reset.

## Timing
- Read latency 0 cycles, combinational from address and valid.
- Write visible to reads the cycle after wb_valid without bypass, the same cycle with bypass.
- Scoreboard set is visible on read_busy_o the cycle after issue.
- Reset deassertion mid-operation: the first post-reset edge accepts writes and issues normally.

## Configuration
- REGFILE_BYPASS_EN
  - Defined: a read whose address matches a same-cycle wb_valid write returns wb_data (highest matching lane) and reports busy 0, unless a same-cycle issue to that addr exists. Such an issue does not affect read_busy_o until the next cycle.
  - Undefined: reads return stored contents and stored busy only. Software-visible latency becomes write-then-read-next-cycle.

## Structure
- Shared package (pipeline_defines): RegNumLog2 = 5, RegNum = 32, RegBus, and a wb_regfile_struct {valid, addr, data} for writeback ports.
- Sub-module regfile_scoreboard: 32-bit busy vector, set/clear/flush priority logic, busy lookup per read port. Main module holds the storage array and bypass muxing.

## Test plan
- Reset then read r1..r31 on all ports -> all data 0, busy 0. Write r0 = 0xFFFFFFFF -> r0 still reads 0.
- Lane0 write r5 = 0x12345678, read r5 the next cycle -> 0x12345678. Same-cycle read -> 0x12345678 with bypass, 0 without.
- Both lanes write r7 (0xAAAA0000 lane0, 0x5555FFFF lane1) -> r7 = 0x5555FFFF.
- Issue r9, next cycle read r9 -> busy 1. Writeback r9 -> busy 0 next cycle, or same cycle with bypass. Simultaneous issue r9 and wb r9 -> busy remains 1.
- Issue r3, r4, then flush together with issue r6 -> all busy 0 next cycle.
- Assert rst_n low mid-stream after writes to r2 -> r2 reads 0 immediately, busy vector 0.
